// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback-data selection.
// Also tracks a sticky misaligned-load flag and a retired-instruction counter.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_data_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic              mem_to_reg,
    input  logic              reg_write_in,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic              valid_out,
    output logic              reg_write_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic              misalign_err,
    output logic [31:0]       retire_count
);

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } load_size_e;

    logic [1:0]        offset;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic              misaligned;

    logic              valid_d, valid_q;
    logic              reg_write_d, reg_write_q;
    logic [REG_AW-1:0] write_reg_d, write_reg_q;
    logic [DATA_W-1:0] write_data_d, write_data_q;
    logic              misalign_d, misalign_q;
    logic [31:0]       retire_d, retire_q;

    assign offset = alu_data_in[1:0];

    // Big-endian lanes: offset 0 addresses the most significant byte.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        byte_sel  = '0;
        half_sel  = '0;
        load_data = '0;
        case (offset)
            2'd0: byte_sel = read_data_in[31:24];
            2'd1: byte_sel = read_data_in[23:16];
            2'd2: byte_sel = read_data_in[15:8];
            2'd3: byte_sel = read_data_in[7:0];
            default: byte_sel = '0;
        endcase
        half_sel = offset[1] ? read_data_in[15:0] : read_data_in[31:16];
        case (load_size_e'(load_size))
            LS_BYTE: load_data = load_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                               : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LS_HALF: load_data = load_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                               : {{(DATA_W-16){half_sel[15]}}, half_sel};
            default: load_data = read_data_in;
        endcase
    end

    assign misaligned = valid_in & mem_to_reg &
                        (((load_size == LS_HALF) & offset[0]) |
                         (load_size[1] & (offset != 2'd0)));

    // Priority: reset > flush > stall > capture.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        misalign_d   = misalign_q;
        retire_d     = retire_q;
        if (flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            write_reg_d  = '0;
            write_data_d = '0;
        end else if (!stall) begin
            valid_d      = valid_in;
            reg_write_d  = reg_write_in & valid_in & (write_reg_in != '0) & ~misaligned;
            write_reg_d  = write_reg_in;
            write_data_d = mem_to_reg ? load_data : alu_data_in;
            misalign_d   = misalign_q | misaligned;
            retire_d     = retire_q + {31'd0, valid_in};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            misalign_q   <= 1'b0;
            retire_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            misalign_q   <= misalign_d;
            retire_q     <= retire_d;
        end
    end

    assign valid_out      = valid_q;
    assign reg_write_out  = reg_write_q;
    assign write_reg_out  = write_reg_q;
    assign write_data_out = write_data_q;
    assign misalign_err   = misalign_q;
    assign retire_count   = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed vectors applied one edge at a time,
// outputs sampled 1 time unit after the rising edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in, mem_to_reg, reg_write_in, load_unsigned;
    logic [31:0] alu_data_in, read_data_in;
    logic [4:0]  write_reg_in;
    logic [1:0]  load_size;
    logic        valid_out, reg_write_out, misalign_err;
    logic [4:0]  write_reg_out;
    logic [31:0] write_data_out, retire_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .alu_data_in(alu_data_in), .read_data_in(read_data_in), .mem_to_reg(mem_to_reg),
        .reg_write_in(reg_write_in), .write_reg_in(write_reg_in), .load_size(load_size),
        .load_unsigned(load_unsigned), .valid_out(valid_out), .reg_write_out(reg_write_out),
        .write_reg_out(write_reg_out), .write_data_out(write_data_out),
        .misalign_err(misalign_err), .retire_count(retire_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic v, input logic rw,
                            input logic [4:0] wr, input logic [31:0] wd);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".rw"}, {31'd0, reg_write_out}, {31'd0, rw});
        check({tag, ".wr"}, {27'd0, write_reg_out}, {27'd0, wr});
        check({tag, ".wd"}, write_data_out, wd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        valid_in = 1'b1; reg_write_in = 1'b1; mem_to_reg = 1'b1; write_reg_in = 5'd7;
        alu_data_in = addr; load_size = sz; load_unsigned = uns;
        read_data_in = 32'h80FF_7F01;
        step();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; mem_to_reg = 1'b0;
        reg_write_in = 1'b0; load_unsigned = 1'b0; alu_data_in = '0; read_data_in = '0;
        write_reg_in = '0; load_size = 2'b10;
        step();
        check_wb("reset0", 1'b0, 1'b0, 5'd0, 32'h0);
        check("reset0.cnt", retire_count, 32'd0);
        check("reset0.mis", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;

        // ALU writeback
        valid_in = 1'b1; reg_write_in = 1'b1; mem_to_reg = 1'b0; write_reg_in = 5'd5;
        alu_data_in = 32'h1234_5678;
        step();
        check_wb("alu", 1'b1, 1'b1, 5'd5, 32'h1234_5678);
        check("alu.cnt", retire_count, 32'd1);

        // Load extraction on 0x80FF7F01
        load(32'h100, 2'b00, 1'b0); check_wb("lb0", 1'b1, 1'b1, 5'd7, 32'hFFFF_FF80);
        load(32'h101, 2'b00, 1'b1); check_wb("lbu1", 1'b1, 1'b1, 5'd7, 32'h0000_00FF);
        load(32'h102, 2'b01, 1'b0); check_wb("lh2", 1'b1, 1'b1, 5'd7, 32'h0000_7F01);
        load(32'h100, 2'b01, 1'b0); check_wb("lh0", 1'b1, 1'b1, 5'd7, 32'hFFFF_80FF);
        load(32'h104, 2'b10, 1'b0); check_wb("lw", 1'b1, 1'b1, 5'd7, 32'h80FF_7F01);
        load(32'h100, 2'b01, 1'b1); check_wb("lhu0", 1'b1, 1'b1, 5'd7, 32'h0000_80FF);
        load(32'h103, 2'b00, 1'b0); check_wb("lb3", 1'b1, 1'b1, 5'd7, 32'h0000_0001);
        load(32'h108, 2'b11, 1'b0); check_wb("lrsvd", 1'b1, 1'b1, 5'd7, 32'h80FF_7F01);
        check("loads.cnt", retire_count, 32'd9);
        check("loads.mis", {31'd0, misalign_err}, 32'd0);

        // Stall holds everything for three cycles
        mem_to_reg = 1'b0; write_reg_in = 5'd9; alu_data_in = 32'hDEAD_0000; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_wb("stall", 1'b1, 1'b1, 5'd7, 32'h80FF_7F01);
            check("stall.cnt", retire_count, 32'd9);
        end

        // Flush beats stall
        flush = 1'b1;
        step();
        check_wb("flush", 1'b0, 1'b0, 5'd0, 32'h0);
        check("flush.cnt", retire_count, 32'd9);
        stall = 1'b0; flush = 1'b0;

        // Bubble: data captured, no write, no count
        valid_in = 1'b0; reg_write_in = 1'b1; write_reg_in = 5'd3; alu_data_in = 32'h55;
        step();
        check_wb("bubble", 1'b0, 1'b0, 5'd3, 32'h55);
        check("bubble.cnt", retire_count, 32'd9);

        // r0 suppression
        valid_in = 1'b1; write_reg_in = 5'd0; alu_data_in = 32'hAA;
        step();
        check_wb("r0", 1'b1, 1'b0, 5'd0, 32'hAA);
        check("r0.cnt", retire_count, 32'd10);

        // Misaligned word load, then misaligned half, then aligned word
        load(32'h102, 2'b10, 1'b0);
        check_wb("mislw", 1'b1, 1'b0, 5'd7, 32'h80FF_7F01);
        check("mislw.mis", {31'd0, misalign_err}, 32'd1);
        check("mislw.cnt", retire_count, 32'd11);
        load(32'h101, 2'b01, 1'b0);
        check("mislh.rw", {31'd0, reg_write_out}, 32'd0);
        load(32'h100, 2'b10, 1'b0);
        check_wb("alignlw", 1'b1, 1'b1, 5'd7, 32'h80FF_7F01);
        check("alignlw.mis", {31'd0, misalign_err}, 32'd1);
        check("alignlw.cnt", retire_count, 32'd13);

        // Counter wrap
        force dut.retire_q = 32'hFFFF_FFFE;
        #1 release dut.retire_q;
        mem_to_reg = 1'b0; write_reg_in = 5'd2; alu_data_in = 32'h1;
        step();
        check("wrap1.cnt", retire_count, 32'hFFFF_FFFF);
        step();
        check("wrap2.cnt", retire_count, 32'h0);

        // Reset mid-traffic
        reset = 1'b1;
        step();
        check_wb("reset1", 1'b0, 1'b0, 5'd0, 32'h0);
        check("reset1.cnt", retire_count, 32'd0);
        check("reset1.mis", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        step();
        check_wb("restart", 1'b1, 1'b1, 5'd2, 32'h1);
        check("restart.cnt", retire_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatting for the DLX pipeline; sits directly downstream of the memory stage and feeds the register-file write port and the forwarding unit.
- Captures ALU result and data-memory read data each cycle, extracts and sign/zero-extends byte/halfword loads, and selects the writeback value.
- Supports stall, flush, r0 write suppression, a misaligned-load flag and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all pipeline registers
- flush  in  1  insert bubble
- valid_in  in  1  MEM-stage slot holds a real instruction
- alu_data_in  in  32  ALU result / memory address from MEM
- read_data_in  in  32  data-memory read word, combinational in the same cycle as alu_data_in
- mem_to_reg  in  1  1 = writeback load data, 0 = ALU result
- reg_write_in  in  1  instruction writes a register
- write_reg_in  in  5  destination register
- load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_unsigned  in  1  zero-extend (LBU/LHU)
- valid_out  out  1  WB slot valid
- reg_write_out  out  1  register-file write enable
- write_reg_out  out  5  register-file write address
- write_data_out  out  32  register-file write data
- misalign_err  out  1  sticky misaligned-load flag
- retire_count  out  32  count of valid retired instructions

Behaviour:
- Reset, synchronous: valid_out, reg_write_out, write_reg_out, write_data_out, misalign_err and retire_count all become 0 on the next rising edge.
- Priority each edge: reset > flush > stall > normal load.
- Normal load, 1-cycle latency: all outputs reflect the MEM-stage inputs present at the preceding edge.
- Flush: valid_out=0, reg_write_out=0, write_reg_out=0, write_data_out=0. Flush overrides a simultaneous stall.
- Stall without flush: every register holds. retire_count does not increment.
- Load extraction uses offset = alu_data_in[1:0], big-endian (offset 0 = bits 31:24):
  - Byte: selects byte[offset].
  - Half: offset 0 selects bits 31:16; offset 2 selects bits 15:0.
  - Word: selects the full word.
  - Extension is sign or zero according to load_unsigned.
- Writeback data = mem_to_reg ? extracted load : alu_data_in, computed combinationally before the register.
- Misalignment: a valid mem_to_reg load that is a half with offset[0]=1, or a word with offset!=0.
  - Captured reg_write_out is forced to 0.
  - valid_out is still 1.
  - misalign_err sets and stays set until reset.
- r0 suppression: captured reg_write_out = reg_write_in & valid_in & (write_reg_in != 0) & ~misaligned.
- valid_in=0 on a normal load captures a bubble with reg_write_out=0. Data fields are still captured.
- retire_count increments by 1 on every edge that captures valid_in=1 (not reset, flush or stall). It wraps 0xFFFFFFFF -> 0.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-operation: drive traffic, assert reset for 1 cycle -> next edge all outputs 0, retire_count=0, misalign_err=0.
- ALU writeback: valid_in=1, reg_write_in=1, mem_to_reg=0, write_reg_in=5, alu_data_in=0x12345678 -> next cycle reg_write_out=1, write_reg_out=5, write_data_out=0x12345678, retire_count=1.
- Load extension, read_data_in=0x80FF7F01:
  - LB offset 0 -> 0xFFFFFF80
  - LBU offset 1 -> 0x000000FF
  - LH offset 2 -> 0x00007F01
  - LH offset 0 -> 0xFFFF80FF
  - LW -> 0x80FF7F01
- Stall/flush: load an instruction, assert stall 3 cycles -> outputs and retire_count unchanged; then stall=1 and flush=1 together -> valid_out=0, reg_write_out=0, write_data_out=0.
- Suppression:
  - write_reg_in=0 with reg_write_in=1 -> reg_write_out=0, valid_out=1, count increments.
  - LW at alu_data_in=0x102 -> reg_write_out=0, misalign_err=1, and it stays 1 after further aligned loads.
- Counter wrap: preload retire_count near 0xFFFFFFFF via force, issue 2 valid instructions -> counts 0xFFFFFFFF then 0x00000000.
